// File: rtl/vdp_pkg.sv
// vdp_pkg: shared types and instruction field layout for the fetch/decode datapath
package vdp_pkg;
    typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
    localparam int OPC_LSB  = 24;
    localparam int OPC_W    = 3;
    localparam int RS_LSB   = 20;
    localparam int RS_W     = 2;
    localparam int RD_LSB   = 16;
    localparam int RD_W     = 2;
    localparam int ADDR_LSB = 0;
    localparam int ADDR_FW  = 16;
    localparam logic [31:0] RSVD_MASK = 32'hF8CC_0000;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_JUMP = 3'b111;
endpackage

// File: rtl/fetch_imem.sv
// fetch_imem: single-port 2^ADDR_W x INST_W instruction memory, synchronous read
// ports: clk; we/addr/wdata write when we=1; otherwise rdata <= mem[addr] on the edge
module fetch_imem #(
    parameter int ADDR_W = 8,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [INST_W-1:0] wdata,
    output logic [INST_W-1:0] rdata
);
    logic [INST_W-1:0] mem [2**ADDR_W];
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        else rdata <= mem[addr];
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: program-load and PC sequencing fetch stage feeding the decoder
// inputs : clk, rst (sync, active high), d_prog/prog_wr/prog_data (load), stall, d_jump/d_a (redirect)
// outputs: d_inst/pc/inst_valid (fetched word), halted (DONE), prog_full (load overflow), illegal
// option : FETCH_RSVD_CHK_EN enables the reserved-bit check that drives illegal
module fetch_unit
    import vdp_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_prog,
    input  logic              prog_wr,
    input  logic [INST_W-1:0] prog_data,
    input  logic              stall,
    input  logic              d_jump,
    input  logic [15:0]       d_a,
    output logic [INST_W-1:0] d_inst,
    output logic [ADDR_W-1:0] pc,
    output logic              inst_valid,
    output logic              halted,
    output logic              prog_full,
    output logic              illegal
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    state_t            state;
    logic [ADDR_W:0]   wr_ptr, prog_len, fa, nxt_fa;
    logic [INST_W-1:0] q;
    logic              we, run_go, jump_take, fetch, bad;
    logic              unused_ok;
    assign unused_ok = ^d_a[15:ADDR_W];
    assign run_go    = state == RUN && !d_prog && !stall;
    assign jump_take = run_go && inst_valid && d_jump;
    assign fetch     = run_go && !jump_take && fa < prog_len;
    assign we        = state == LOAD && d_prog && prog_wr && wr_ptr != DEPTH;
    // The memory always reads the address fa will hold after this edge, so q == mem[fa]
    // whenever a fetch is decided and the word can be inspected before it is presented.
    assign nxt_fa = (state == LOAD && !d_prog) ? '0 :
                    jump_take ? {1'b0, d_a[ADDR_W-1:0]} :
                    fetch ? fa + 1'b1 : fa;
`ifdef FETCH_RSVD_CHK_EN
    assign bad = |(q & RSVD_MASK);
`else
    assign bad = 1'b0;
`endif
    assign halted = state == DONE;
    fetch_imem #(.ADDR_W(ADDR_W), .INST_W(INST_W)) u_imem (
        .clk  (clk),
        .we   (we),
        .addr (we ? wr_ptr[ADDR_W-1:0] : nxt_fa[ADDR_W-1:0]),
        .wdata(prog_data),
        .rdata(q)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= DONE;
            d_inst     <= '0;
            pc         <= '0;
            inst_valid <= 1'b0;
            prog_full  <= 1'b0;
            illegal    <= 1'b0;
            wr_ptr     <= '0;
            prog_len   <= '0;
            fa         <= '0;
        end else begin
            fa <= nxt_fa;
            if (d_prog && state != LOAD) begin
                state      <= LOAD;
                wr_ptr     <= '0;
                prog_len   <= '0;
                prog_full  <= 1'b0;
                illegal    <= 1'b0;
                inst_valid <= 1'b0;
            end else if (state == LOAD) begin
                if (!d_prog) state <= prog_len != '0 ? RUN : DONE;
                else if (prog_wr && wr_ptr == DEPTH) prog_full <= 1'b1;
                else if (prog_wr) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    prog_len <= wr_ptr + 1'b1;
                end
            end else if (run_go) begin
                if (jump_take) inst_valid <= 1'b0;
                else if (!fetch || bad) begin
                    state      <= DONE;
                    inst_valid <= 1'b0;
                    illegal    <= illegal | bad;
                end else begin
                    d_inst     <= q;
                    pc         <= fa[ADDR_W-1:0];
                    inst_valid <= 1'b1;
                end
            end
        end
    end
endmodule
